// File: rtl/fetch_decode_ctrl.sv
// Sequencer for the single-cycle MIPS core: fetches over req/ack, decodes the
// instruction into the core's control word and commits the next PC after execute.
module fetch_decode_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic [31:0] pc_res,
  input  logic        pc_sel,
  output logic [31:0] pc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [25:0] addr,
  output logic [1:0]  pc_next,
  output logic [1:0]  reg_dst,
  output logic [1:0]  reg_in,
  output logic        alu_src,
  output logic        reg_we,
  output logic        mem_we,
  output logic        beq,
  output logic        bne,
  output logic [1:0]  alu_ctrl,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_HALT} state_t;

  typedef struct packed {
    logic [1:0] pc_next;
    logic [1:0] reg_dst;
    logic [1:0] reg_in;
    logic       alu_src;
    logic       reg_we;
    logic       mem_we;
    logic       beq;
    logic       bne;
    logic [1:0] alu_ctrl;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [31:0] ir;
  logic [3:0]  cnt;
  ctrl_t       dec, cw_q, cw_o;
  logic        dec_ok;
  logic        last;

  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    case (ir[31:26])
      6'h00: case (ir[5:0])
        6'h20: begin dec.reg_dst = 2'b01; dec.alu_src = 1'b1; dec.reg_we = 1'b1; end
        6'h22: begin dec.reg_dst = 2'b01; dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.alu_ctrl = 2'b01; end
        6'h2A: begin dec.reg_dst = 2'b01; dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.alu_ctrl = 2'b11; end
        6'h08: dec.pc_next = 2'b10;
        default: dec_ok = 1'b0;
      endcase
      6'h08: dec.reg_we = 1'b1;
      6'h0E: begin dec.reg_we = 1'b1; dec.alu_ctrl = 2'b10; end
      6'h23: begin dec.reg_we = 1'b1; dec.reg_in = 2'b01; end
      6'h2B: dec.mem_we = 1'b1;
      6'h04: begin dec.beq = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = 2'b01; end
      6'h05: begin dec.bne = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = 2'b01; end
      6'h02: dec.pc_next = 2'b01;
      6'h03: begin dec.pc_next = 2'b01; dec.reg_dst = 2'b10; dec.reg_in = 2'b10; dec.reg_we = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
  end

  assign last = (cnt == 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = (pc[1:0] != 2'b00) ? S_HALT : S_WAIT;
      S_WAIT:   if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = dec_ok ? S_EXEC : S_HALT;
      S_EXEC:   if (last) state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      cnt     <= '0;
      cw_q    <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_WAIT:   if (imem_ack) ir <= imem_data;
        S_DECODE: begin
          cw_q <= dec;
          cnt  <= 4'(EXEC_CYCLES - 1);
        end
        S_EXEC: begin
          if (last) begin
            pc      <= pc_sel ? pc_res : pc + 32'd4;
            retired <= retired + 32'd1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control word is only visible in EXEC; write enables fire on the last cycle only.
  assign cw_o      = (state_q == S_EXEC) ? cw_q : '0;
  assign pc_next   = cw_o.pc_next;
  assign reg_dst   = cw_o.reg_dst;
  assign reg_in    = cw_o.reg_in;
  assign alu_src   = cw_o.alu_src;
  assign reg_we    = cw_o.reg_we & last;
  assign mem_we    = cw_o.mem_we & last;
  assign beq       = cw_o.beq;
  assign bne       = cw_o.bne;
  assign alu_ctrl  = cw_o.alu_ctrl;

  assign imem_req  = (state_q == S_WAIT);
  assign imem_addr = pc;
  assign illegal   = (state_q == S_HALT);

  assign rs   = ir[25:21];
  assign rt   = ir[20:16];
  assign rd   = ir[15:11];
  assign imm  = ir[15:0];
  assign addr = ir[25:0];

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: directed scenarios plus random legal instruction
// streams checked against a table-driven decode and PC/retire model.
module tb_fetch_decode_ctrl;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int          E   = 3;

  logic        clk, rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data, pc_res, pc, retired;
  logic        pc_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] addr;
  logic [1:0]  pc_next, reg_dst, reg_in, alu_ctrl;
  logic        alu_src, reg_we, mem_we, beq, bne, illegal;
  logic [12:0] obs;

  fetch_decode_ctrl #(.RESET_PC(RPC), .EXEC_CYCLES(E)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .pc_res(pc_res), .pc_sel(pc_sel),
    .pc(pc), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .addr(addr),
    .pc_next(pc_next), .reg_dst(reg_dst), .reg_in(reg_in), .alu_src(alu_src),
    .reg_we(reg_we), .mem_we(mem_we), .beq(beq), .bne(bne), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .retired(retired)
  );

  assign obs = {pc_next, reg_dst, reg_in, alu_src, reg_we, mem_we, beq, bne, alu_ctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: decode table {op, funct, uses-funct, control word} and PC/retire counters.
  logic [5:0]  t_op [12];
  logic [5:0]  t_fn [12];
  logic        t_r  [12];
  logic [12:0] t_cw [12];
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic init_tbl();
    //            pn dst in  s w m q n alu
    t_op[0]  = 6'h00; t_fn[0]  = 6'h20; t_r[0]  = 1; t_cw[0]  = 13'b00_01_00_1_1_0_0_0_00;
    t_op[1]  = 6'h00; t_fn[1]  = 6'h22; t_r[1]  = 1; t_cw[1]  = 13'b00_01_00_1_1_0_0_0_01;
    t_op[2]  = 6'h00; t_fn[2]  = 6'h2A; t_r[2]  = 1; t_cw[2]  = 13'b00_01_00_1_1_0_0_0_11;
    t_op[3]  = 6'h00; t_fn[3]  = 6'h08; t_r[3]  = 1; t_cw[3]  = 13'b10_00_00_0_0_0_0_0_00;
    t_op[4]  = 6'h08; t_fn[4]  = 6'h00; t_r[4]  = 0; t_cw[4]  = 13'b00_00_00_0_1_0_0_0_00;
    t_op[5]  = 6'h0E; t_fn[5]  = 6'h00; t_r[5]  = 0; t_cw[5]  = 13'b00_00_00_0_1_0_0_0_10;
    t_op[6]  = 6'h23; t_fn[6]  = 6'h00; t_r[6]  = 0; t_cw[6]  = 13'b00_00_01_0_1_0_0_0_00;
    t_op[7]  = 6'h2B; t_fn[7]  = 6'h00; t_r[7]  = 0; t_cw[7]  = 13'b00_00_00_0_0_1_0_0_00;
    t_op[8]  = 6'h04; t_fn[8]  = 6'h00; t_r[8]  = 0; t_cw[8]  = 13'b00_00_00_1_0_0_1_0_01;
    t_op[9]  = 6'h05; t_fn[9]  = 6'h00; t_r[9]  = 0; t_cw[9]  = 13'b00_00_00_1_0_0_0_1_01;
    t_op[10] = 6'h02; t_fn[10] = 6'h00; t_r[10] = 0; t_cw[10] = 13'b01_00_00_0_0_0_0_0_00;
    t_op[11] = 6'h03; t_fn[11] = 6'h00; t_r[11] = 0; t_cw[11] = 13'b01_10_10_0_1_0_0_0_00;
  endtask

  function automatic void model_dec(input logic [31:0] w, output logic ok, output logic [12:0] cw);
    ok = 1'b0;
    cw = '0;
    for (int i = 0; i < 12; i++)
      if (t_op[i] == w[31:26] && (!t_r[i] || t_fn[i] == w[5:0])) begin
        ok = 1'b1;
        cw = t_cw[i];
      end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; pc_sel = 1'b0; pc_res = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RPC;
    m_ret = '0;
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves it the same way
  // (or halted, for an unsupported word).
  task automatic run_instr(input logic [31:0] w, input int nwait, input logic sel,
                           input logic [31:0] res);
    logic        ok;
    logic [12:0] cw, exp;
    logic [57:0] fexp;
    model_dec(w, ok, cw);
    fexp = {w[25:21], w[20:16], w[15:11], w[15:0], w[25:0]};
    n_cmp++;
    if (imem_req !== 1'b0 || obs !== 13'h0) begin
      n_bad++; $display("FAIL fetch_idle req=%b cw=%h required req=0 cw=0", imem_req, obs);
    end
    for (int i = 0; i <= nwait; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || obs !== 13'h0) begin
        n_bad++; $display("FAIL wait_req req=%b addr=%h cw=%h required req=1 addr=%h cw=0",
                          imem_req, imem_addr, obs, m_pc);
      end
      if (i == nwait) begin imem_ack = 1'b1; imem_data = w; end
    end
    @(negedge clk);
    imem_ack = 1'b0; imem_data = $urandom;
    pc_sel = sel; pc_res = res;
    n_cmp++;
    if (imem_req !== 1'b0 || obs !== 13'h0 || illegal !== 1'b0 || {rs, rt, rd, imm, addr} !== fexp) begin
      n_bad++; $display("FAIL decode_idle req=%b cw=%h ill=%b fields=%h required 0/0/0/%h",
                        imem_req, obs, illegal, {rs, rt, rd, imm, addr}, fexp);
    end
    if (!ok) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_cmp++;
        if (illegal !== 1'b1 || imem_req !== 1'b0 || obs !== 13'h0 || pc !== m_pc) begin
          n_bad++; $display("FAIL halt_state ill=%b req=%b cw=%h pc=%h required 1/0/0/%h",
                            illegal, imem_req, obs, pc, m_pc);
        end
      end
      pc_sel = 1'b0;
      return;
    end
    for (int k = 0; k < E; k++) begin
      @(negedge clk);
      exp = (k == E - 1) ? cw : (cw & ~13'h0030);
      n_cmp++;
      if (obs !== exp || {rs, rt, rd, imm, addr} !== fexp || pc !== m_pc || imem_req !== 1'b0) begin
        n_bad++; $display("FAIL exec_cw k=%0d w=%h cw=%h fields=%h pc=%h required cw=%h fields=%h pc=%h",
                          k, w, obs, {rs, rt, rd, imm, addr}, pc, exp, fexp, m_pc);
      end
      imem_ack = 1'b1;  // stray ack outside WAIT must be ignored
    end
    @(negedge clk);
    imem_ack = 1'b0; pc_sel = 1'b0; pc_res = $urandom;
    m_pc  = sel ? res : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    n_cmp++;
    if (pc !== m_pc || retired !== m_ret || obs !== 13'h0 || {rs, rt, rd, imm, addr} !== fexp) begin
      n_bad++; $display("FAIL commit pc=%h ret=%0d cw=%h fields=%h required pc=%h ret=%0d cw=0 fields=%h",
                        pc, retired, obs, {rs, rt, rd, imm, addr}, m_pc, m_ret, fexp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; pc_sel = 1'b0; pc_res = '0;
    #12;
    n_cmp++;
    if (pc !== RPC || retired !== 32'd0 || illegal !== 1'b0 || imem_req !== 1'b0 ||
        obs !== 13'h0 || {rs, rt, rd, imm, addr} !== 58'h0) begin
      n_bad++; $display("FAIL reset_state pc=%h ret=%0d ill=%b req=%b cw=%h required pc=%h rest 0",
                        pc, retired, illegal, imem_req, obs, RPC);
    end
    do_reset();
  endtask

  task automatic test_addi();
    run_instr(32'h2008_0005, 3, 1'b0, 32'h0);
    n_cmp++;
    if (pc !== 32'h0040_0004 || retired !== 32'd1) begin
      n_bad++; $display("FAIL addi_commit pc=%h ret=%0d required pc=00400004 ret=1", pc, retired);
    end
  endtask

  task automatic test_branch_jump();
    run_instr(32'h1000_0002, 0, 1'b1, 32'h0040_0010);
    n_cmp++;
    if (pc !== 32'h0040_0010) begin
      n_bad++; $display("FAIL beq_target pc=%h required 00400010", pc);
    end
    run_instr(32'h0810_0004, 1, 1'b1, 32'h0040_0010);
    run_instr(32'hAC09_0004, 2, 1'b0, 32'h0);
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(32'hFC00_0000, 1, 1'b0, 32'h0);
    n_cmp++;
    if (pc !== RPC || retired !== 32'd0) begin
      n_bad++; $display("FAIL illegal_frozen pc=%h ret=%0d required pc=%h ret=0", pc, retired, RPC);
    end
    do_reset();
    run_instr(32'h0000_0021, 0, 1'b0, 32'h0);  // ADDU: unsupported funct
  endtask

  task automatic test_misaligned();
    do_reset();
    run_instr(32'h03E0_0008, 0, 1'b1, 32'h0040_0002);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (illegal !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0040_0002) begin
        n_bad++; $display("FAIL misaligned_halt ill=%b req=%b pc=%h required 1/0/00400002",
                          illegal, imem_req, pc);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    run_instr(32'h2008_0005, 0, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || pc !== RPC || retired !== 32'd0 || obs !== 13'h0 || illegal !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_wait req=%b pc=%h ret=%0d cw=%h required 0/%h/0/0",
                        imem_req, pc, retired, obs, RPC);
    end
    do_reset();
    run_instr(32'h3929_00FF, 2, 1'b0, 32'h0);  // XORI, refetched from RESET_PC
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          idx;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 11));
      w = {t_op[idx], 26'($urandom)};
      if (t_r[idx]) w[5:0] = t_fn[idx];
      run_instr(w, int'($urandom_range(0, 4)), 1'($urandom), {30'($urandom), 2'b00});
    end
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_addi();
    test_branch_jump();
    test_illegal();
    test_misaligned();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Sequencing and control unit that drives the single-cycle MIPS datapath core.
- Owns the PC register and fetches instructions from instruction memory over a req/ack handshake.
- Decodes each instruction into the core's control word (pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, mem_we, beq, bne) and presents it for one execute window.
- Commits the next PC from the core's pcRes/myPc feedback.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXEC_CYCLES, 1, execute-window length in cycles (1..15); lets slow data memory settle.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, held until acknowledged.
- imem_addr  output  32  fetch address (= pc).
- imem_ack  input  1  instruction data valid this cycle.
- imem_data  input  32  instruction word.
- pc_res  input  32  next-PC candidate from core (pcRes).
- pc_sel  input  1  core reports non-sequential PC (myPc).
- pc  output  32  current PC (core pcIn).
- rs, rt, rd  output  5 each  register fields of the latched instruction.
- imm  output  16  instr[15:0].
- addr  output  26  instr[25:0].
- pc_next, reg_dst, reg_in  output  2 each  control word.
- alu_src, reg_we, mem_we, beq, bne  output  1 each  control word.
- alu_ctrl  output  2  ALU command.
- illegal  output  1  sticky: unsupported opcode/funct or misaligned PC.
- retired  output  32  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, IR=0, state=FETCH, retired=0, illegal=0.
  - All control outputs 0; imem_req=0.
  - Reset mid-fetch or mid-exec abandons the instruction with no write enables.
- States: FETCH -> WAIT -> DECODE -> EXEC -> FETCH; HALT is terminal until reset.
- FETCH (1 cycle): if pc[1:0]!=0, go to HALT with illegal=1; else imem_req<=1 and go to WAIT.
- WAIT:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack=1.
  - On ack: IR<=imem_data, imem_req<=0, go to DECODE.
  - An ack arriving while req=0 is ignored.
- DECODE (1 cycle):
  - Registers the control word from IR; an unsupported encoding goes to HALT with illegal=1.
  - Otherwise load the exec counter with EXEC_CYCLES-1 and go to EXEC.
- EXEC:
  - Control word held stable for EXEC_CYCLES cycles.
  - reg_we and mem_we are asserted only in the final EXEC cycle (single pulse).
  - At the end of the final cycle: pc <= pc_sel ? pc_res : pc+4 (mod 2^32), retired <= retired+1 (wraps), go to FETCH.
- Outside EXEC, all control outputs are 0. rs/rt/rd/imm/addr always reflect IR.
- HALT: outputs 0, imem_req=0, illegal=1, pc frozen.
- Encodings:
  - alu_ctrl: 00 ADD, 01 SUB, 10 XOR, 11 SLT.
  - alu_src: 0 sign-extended immediate, 1 register B.
  - reg_dst: 00 rt, 01 rd, 10 r31.
  - reg_in: 00 ALU, 01 memory, 10 pc+4.
  - pc_next: 00 sequential/branch, 01 jump, 10 register.
- Decode table (fields not listed are 0):
  - R-type op 0x00, funct 0x20/0x22/0x2A: reg_dst=01, alu_src=1, reg_we=1, alu_ctrl ADD/SUB/SLT.
  - JR op 0x00, funct 0x08: pc_next=10.
  - ADDI 0x08: reg_we=1, ADD.
  - XORI 0x0E: reg_we=1, XOR.
  - LW 0x23: reg_we=1, reg_in=01, ADD.
  - SW 0x2B: mem_we=1, ADD.
  - BEQ 0x04: beq=1, alu_src=1, SUB.
  - BNE 0x05: bne=1, alu_src=1, SUB.
  - J 0x02: pc_next=01.
  - JAL 0x03: pc_next=01, reg_dst=10, reg_in=10, reg_we=1.
  - Anything else is illegal.
- Minimum instruction latency is 3+EXEC_CYCLES cycles with a 1-cycle ack.

Test Plan:
- Reset with RESET_PC=0x0040_0000, then ack after 3 wait cycles returning 0x20080005 (ADDI) -> imem_addr=0x0040_0000 with req held 3 cycles; in EXEC, rt=8, imm=0x0005, alu_src=0, reg_we pulses once; pc becomes 0x0040_0004; retired=1.
- BEQ 0x10000002, core returns pc_sel=1 and pc_res=0x0040_0010 -> beq=1, alu_ctrl=01; next imem_addr=0x0040_0010.
- J 0x08100004 -> pc_next=01, addr=0x100004; with pc_sel=1 and pc_res=0x0040_0010, next fetch goes to 0x0040_0010.
- JR with pc_sel=1 and pc_res=0x0040_0002 -> next FETCH goes to HALT: illegal=1, imem_req stays 0.
- Word 0xFC000000 -> illegal=1, no reg_we/mem_we pulse, pc unchanged.
- EXEC_CYCLES=3, SW 0xAC090004 -> control word stable for 3 cycles, mem_we high only in cycle 3.
- rst_n dropped mid-WAIT -> all outputs 0 immediately; refetch from RESET_PC.
